leaf_out_arbiter: RTL and testbench
===================================

LEAF_OUT_ARBITER -- requirements
Module: leaf_out_arbiter

Interface
REQ-001 SHALL have parameter NUM_OUT_PORTS, default 4: user output channels, legal 1..16.
REQ-002 SHALL have parameter PAYLOAD_BITS, default 32: user word width.
REQ-003 SHALL have parameter NUM_LEAF_BITS, default 5: destination leaf field width.
REQ-004 SHALL have parameter NUM_PORT_BITS, default 4: destination port field width.
REQ-005 SHALL have parameter NUM_ADDR_BITS, default 7: per-port sequence address width.
REQ-006 SHALL have parameter NUM_BRAM_ADDR_BITS, default 7: remote buffer depth is 2^N words.
REQ-007 SHALL have parameter FREESPACE_UPDATE_SIZE, default 64: credits returned per update.
REQ-008 SHALL derive localparam PACKET_BITS = 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS (49 at defaults).
REQ-009 SHALL provide the following ports:
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-low.
- din_leaf_user2interface, in, NUM_OUT_PORTS*PAYLOAD_BITS: user words, port i at slice i.
- vld_user2interface, in, NUM_OUT_PORTS: user word valid.
- ack_interface2user, out, NUM_OUT_PORTS: word accepted.
- dout_leaf_interface2bft, out, PACKET_BITS: packet to BFT.
- bft_ready, in, 1: BFT consumes the current packet.
- resend, in, 1: pause and blank output.
- cfg_wr, in, 1: destination-table write strobe.
- cfg_port, in, NUM_PORT_BITS: table index.
- cfg_dest, in, 1+NUM_LEAF_BITS+NUM_PORT_BITS: {enable, leaf, port}.
- credit_upd, in, 1: freespace return strobe.
- credit_port, in, NUM_PORT_BITS: port receiving credits.

Function
REQ-010 Packet format SHALL be, MSB to LSB: {valid=1, dest_leaf, dest_port, addr, payload}.
REQ-011 Output register SHALL have two states: EMPTY (dout=0) and FULL; FULL->EMPTY on bft_ready with no new grant; stays FULL on bft_ready with a grant (new packet loaded); EMPTY->FULL on a grant.
REQ-012 A slot SHALL be free when the register is EMPTY, or FULL with bft_ready=1 and resend=0.
REQ-013 Port i SHALL be eligible when vld[i]=1, its table enable=1, credit[i]>0, and resend=0.
REQ-014 At most one port SHALL be granted per cycle, and only when a slot is free; selection is round-robin starting at last_grant+1 mod NUM_OUT_PORTS.
REQ-015 ack_interface2user[g] SHALL assert combinationally in the grant cycle; the transfer occurs on vld&ack.
REQ-016 The granted word SHALL appear on dout the cycle after the grant (latency 1).
REQ-017 Per-port addr counter SHALL start at 0, increment per grant, and wrap at 2^NUM_ADDR_BITS-1 -> 0.
REQ-018 Per-port credit counter SHALL be NUM_BRAM_ADDR_BITS+1 bits, reset to 2^NUM_BRAM_ADDR_BITS, decrement by 1 per grant, and increase by FREESPACE_UPDATE_SIZE per credit_upd, saturating at the reset value.
REQ-019 When a grant and credit_upd hit the same port in the same cycle, the net change SHALL be applied (+SIZE-1, then saturate).
REQ-020 cfg_wr SHALL take effect from the next cycle; writes with cfg_port>=NUM_OUT_PORTS, or credit_upd with credit_port>=NUM_OUT_PORTS, SHALL be ignored.
REQ-021 While resend=1: no grants, output register and state held, dout forced to 0; after resend falls, the held packet SHALL reappear unchanged.
REQ-022 A packet already in the register SHALL keep the destination captured at its grant, even if the table is rewritten.

Reset
REQ-023 Asserting reset SHALL immediately force: ack=0, dout=0, state EMPTY, last_grant=NUM_OUT_PORTS-1, addr=0, credits=2^NUM_BRAM_ADDR_BITS, all table enables=0.
REQ-024 Reset asserted mid-transfer SHALL discard the held packet; deassertion is synchronised externally.

Structure
REQ-025 Packet-field offsets and the PACKET_BITS formula SHALL live in a shared leaf package used with leaf_interface.
REQ-026 The round-robin selector SHALL be the single sub-module rr_arbiter (parameter N; inputs req, last; output one-hot grant).

Verification
REQ-027 Ports 0 and 2 configured, both vld held high, bft_ready=1 -> grants alternate 0,2,0,2; addr fields 0,0,1,1.
REQ-028 Single port, bft_ready=1, 129 words offered -> 128 acks, then ack=0; one credit_upd -> acks resume for 64 more words.
REQ-029 bft_ready=0 with a packet FULL -> dout stable, no acks; bft_ready=1 -> next grant that cycle, new packet the following cycle.
REQ-030 resend pulsed 3 cycles while FULL -> dout=0 for 3 cycles, then the original packet (same addr, payload) returns.
REQ-031 Port 1 sent 127 packets, then one more -> addr field 127, then 0; credit_upd in the same cycle as a grant -> credit = prior+63.
REQ-032 Reset asserted with FULL register and credit=5 -> dout=0 and ack=0 at once; after release, credit=128 and enables=0.

Source files
------------

// File: rtl/leaf_out_arbiter_pkg.sv
// Shared leaf-interface definitions: packet layout helpers and output-register states.
package leaf_out_arbiter_pkg;

  // Output register occupancy.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Total packet width: {valid, leaf, port, addr, payload}.
  function automatic int unsigned packet_bits(input int unsigned leaf_bits,
                                               input int unsigned port_bits,
                                               input int unsigned addr_bits,
                                               input int unsigned payload_bits);
    return 1 + leaf_bits + port_bits + addr_bits + payload_bits;
  endfunction

  // Field LSB offsets inside a packet, payload at bit 0.
  function automatic int unsigned addr_lsb(input int unsigned payload_bits);
    return payload_bits;
  endfunction

  function automatic int unsigned port_lsb(input int unsigned payload_bits,
                                           input int unsigned addr_bits);
    return payload_bits + addr_bits;
  endfunction

  function automatic int unsigned leaf_lsb(input int unsigned payload_bits,
                                           input int unsigned addr_bits,
                                           input int unsigned port_bits);
    return payload_bits + addr_bits + port_bits;
  endfunction

  function automatic int unsigned valid_bit(input int unsigned payload_bits,
                                            input int unsigned addr_bits,
                                            input int unsigned port_bits,
                                            input int unsigned leaf_bits);
    return payload_bits + addr_bits + port_bits + leaf_bits;
  endfunction

  // Index width for n channels; never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr_arbiter.sv
// Round-robin selector: first requester after 'last', wrapping, one-hot grant.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant
);

  logic [LW-1:0] idx;
  logic          found;

  // Scan N positions starting one past the previous winner.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = LW'((32'(last) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Leaf output arbiter: credit-gated round-robin merge of user channels into
// one BFT packet register with per-port sequence addresses and a destination table.
module leaf_out_arbiter
  import leaf_out_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_OUT_PORTS         = 4,
  parameter  int unsigned PAYLOAD_BITS          = 32,
  parameter  int unsigned NUM_LEAF_BITS         = 5,
  parameter  int unsigned NUM_PORT_BITS         = 4,
  parameter  int unsigned NUM_ADDR_BITS         = 7,
  parameter  int unsigned NUM_BRAM_ADDR_BITS    = 7,
  parameter  int unsigned FREESPACE_UPDATE_SIZE = 64,
  localparam int unsigned PACKET_BITS = packet_bits(NUM_LEAF_BITS, NUM_PORT_BITS,
                                                    NUM_ADDR_BITS, PAYLOAD_BITS),
  localparam int unsigned DEST_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
  input  logic                                    bft_ready,
  input  logic                                    resend,
  input  logic                                    cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]                cfg_port,
  input  logic [DEST_BITS-1:0]                    cfg_dest,
  input  logic                                    credit_upd,
  input  logic [NUM_PORT_BITS-1:0]                credit_port
);

  localparam int unsigned IDX_BITS    = idx_bits(NUM_OUT_PORTS);
  localparam int unsigned CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(1 << NUM_BRAM_ADDR_BITS);

  // Destination table.
  logic                     dest_en_q   [NUM_OUT_PORTS];
  logic                     dest_en_d   [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] dest_leaf_q [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] dest_leaf_d [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port_q [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port_d [NUM_OUT_PORTS];

  // Per-port sequence address and remote freespace credit.
  logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_d   [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];

  // Output register.
  out_state_e               state_q, state_d;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d, new_pkt;
  logic [IDX_BITS-1:0]      last_q, last_d, grant_idx;

  logic [NUM_OUT_PORTS-1:0] eligible, req, grant;
  logic                     slot_free, any_grant, upd_hit;
  logic [31:0]              credit_sum;

  // A slot opens when the register is empty or its packet leaves this cycle.
  always_comb begin
    slot_free = (state_q == OUT_EMPTY) || (bft_ready && !resend);
    eligible  = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = vld_user2interface[i] && dest_en_q[i] &&
                    (credit_q[i] != '0) && !resend;
    end
    req = slot_free ? eligible : '0;
  end

  rr_arbiter #(
    .N (NUM_OUT_PORTS)
  ) u_rr (
    .req   (req),
    .last  (last_q),
    .grant (grant)
  );

  // Decode the winner and assemble its packet with the destination current at grant time.
  always_comb begin
    any_grant = |grant;
    grant_idx = '0;
    new_pkt   = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant[i]) begin
        grant_idx = IDX_BITS'(i);
        new_pkt   = {1'b1, dest_leaf_q[i], dest_port_q[i], addr_q[i],
                     din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    end
  end

  // Destination table writes; out-of-range indices match no entry.
  always_comb begin
    dest_en_d   = dest_en_q;
    dest_leaf_d = dest_leaf_q;
    dest_port_d = dest_port_q;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      if (cfg_wr && (32'(cfg_port) == i)) begin
        dest_en_d[i]   = cfg_dest[DEST_BITS-1];
        dest_leaf_d[i] = cfg_dest[NUM_PORT_BITS +: NUM_LEAF_BITS];
        dest_port_d[i] = cfg_dest[0 +: NUM_PORT_BITS];
      end
    end
  end

  // Address and credit updates; grant and credit return on one port net out, then saturate.
  always_comb begin
    addr_d     = addr_q;
    credit_d   = credit_q;
    upd_hit    = 1'b0;
    credit_sum = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      upd_hit    = credit_upd && (32'(credit_port) == i);
      credit_sum = 32'(credit_q[i]);
      if (upd_hit) begin
        credit_sum = credit_sum + 32'(FREESPACE_UPDATE_SIZE);
      end
      if (grant[i]) begin
        credit_sum = credit_sum - 32'd1;
        addr_d[i]  = addr_q[i] + NUM_ADDR_BITS'(1);
      end
      if (credit_sum > 32'(CREDIT_MAX)) begin
        credit_sum = 32'(CREDIT_MAX);
      end
      credit_d[i] = CREDIT_BITS'(credit_sum);
    end
  end

  // Output register next state; resend freezes everything.
  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    last_d  = last_q;
    if (any_grant) begin
      last_d = grant_idx;
    end
    case (state_q)
      OUT_EMPTY: begin
        if (any_grant) begin
          state_d = OUT_FULL;
          pkt_d   = new_pkt;
        end
      end
      OUT_FULL: begin
        if (bft_ready && !resend) begin
          if (any_grant) begin
            pkt_d = new_pkt;
          end else begin
            state_d = OUT_EMPTY;
          end
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= OUT_EMPTY;
      pkt_q   <= '0;
      last_q  <= IDX_BITS'(NUM_OUT_PORTS - 1);
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        dest_en_q[i]   <= 1'b0;
        dest_leaf_q[i] <= '0;
        dest_port_q[i] <= '0;
        addr_q[i]      <= '0;
        credit_q[i]    <= CREDIT_MAX;
      end
    end else begin
      state_q     <= state_d;
      pkt_q       <= pkt_d;
      last_q      <= last_d;
      dest_en_q   <= dest_en_d;
      dest_leaf_q <= dest_leaf_d;
      dest_port_q <= dest_port_d;
      addr_q      <= addr_d;
      credit_q    <= credit_d;
    end
  end

  assign ack_interface2user      = grant;
  assign dout_leaf_interface2bft = ((state_q == OUT_FULL) && !resend) ? pkt_q : '0;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Scoreboard bench for leaf_out_arbiter: directed sequences push expected packets,
// a monitor pops and compares every packet the BFT consumes.
module tb_leaf_out_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 32;

  logic          clk;
  logic          reset;
  logic [N*PW-1:0] din;
  logic [N-1:0]  vld;
  logic [N-1:0]  ack;
  logic [48:0]   dout;
  logic          bft_ready;
  logic          resend;
  logic          cfg_wr;
  logic [3:0]    cfg_port;
  logic [9:0]    cfg_dest;
  logic          credit_upd;
  logic [3:0]    credit_port;

  int            n_vec = 0;
  int            n_mis = 0;
  logic [63:0]   exp_q [$];
  int            word_cnt [N];
  int            ack_cnt  [N];
  logic [N-1:0]  acc_s;
  int            base;

  leaf_out_arbiter #(
    .NUM_OUT_PORTS         (4),
    .PAYLOAD_BITS          (32),
    .NUM_LEAF_BITS         (5),
    .NUM_PORT_BITS         (4),
    .NUM_ADDR_BITS         (7),
    .NUM_BRAM_ADDR_BITS    (7),
    .FREESPACE_UPDATE_SIZE (64)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .dout_leaf_interface2bft (dout),
    .bft_ready               (bft_ready),
    .resend                  (resend),
    .cfg_wr                  (cfg_wr),
    .cfg_port                (cfg_port),
    .cfg_dest                (cfg_dest),
    .credit_upd              (credit_upd),
    .credit_port             (credit_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int p, input int k);
    return {8'(p), 24'(k)};
  endfunction

  function automatic logic [63:0] pkt(input int leaf, input int dport, input int addr,
                                      input logic [31:0] payload);
    logic [48:0] p;
    p = {1'b1, 5'(leaf), 4'(dport), 7'(addr), payload};
    return 64'(p);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int p, input bit en, input int leaf, input int dport);
    cfg_port = 4'(p);
    cfg_dest = {en, 5'(leaf), 4'(dport)};
    cfg_wr   = 1'b1;
    @(posedge clk);
    #1;
    cfg_wr   = 1'b0;
  endtask

  // User side: advance each channel's word after every accepted transfer.
  initial begin
    for (int p = 0; p < N; p++) begin
      word_cnt[p] = 0;
      ack_cnt[p]  = 0;
      din[p*PW +: PW] = word(p, 0);
    end
    forever begin
      @(negedge clk);
      acc_s = ack & vld;
      @(posedge clk);
      #1;
      if (reset) begin
        for (int p = 0; p < N; p++) begin
          if (acc_s[p]) begin
            word_cnt[p]++;
            ack_cnt[p]++;
            din[p*PW +: PW] = word(p, word_cnt[p]);
          end
        end
      end
    end
  end

  // Monitor: every packet consumed by the BFT is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset && bft_ready && !resend && dout[48]) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pkt", 64'(dout), 64'(0));
      end else begin
        check("pkt", 64'(dout), exp_q.pop_front());
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    vld         = '0;
    bft_ready   = 1'b0;
    resend      = 1'b0;
    cfg_wr      = 1'b0;
    cfg_port    = '0;
    cfg_dest    = '0;
    credit_upd  = 1'b0;
    credit_port = '0;

    // Reset state.
    @(negedge clk);
    check("reset_ack", 64'(ack), 64'(0));
    check("reset_dout", 64'(dout), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Two ports alternate round-robin from port 0.
    do_cfg(0, 1'b1, 3, 1);
    do_cfg(2, 1'b1, 7, 5);
    exp_q.push_back(pkt(3, 1, 0, word(0, 0)));
    exp_q.push_back(pkt(7, 5, 0, word(2, 0)));
    exp_q.push_back(pkt(3, 1, 1, word(0, 1)));
    exp_q.push_back(pkt(7, 5, 1, word(2, 1)));
    bft_ready = 1'b1;
    vld = 4'b0101;
    cycles(4);
    vld = '0;
    cycles(3);
    check("rr_acks_p0", 64'(ack_cnt[0]), 64'(2));
    check("rr_acks_p2", 64'(ack_cnt[2]), 64'(2));

    // Backpressure holds the packet and blocks grants.
    exp_q.push_back(pkt(3, 1, 2, word(0, 2)));
    exp_q.push_back(pkt(3, 1, 3, word(0, 3)));
    bft_ready = 1'b0;
    vld = 4'b0001;
    cycles(1);
    repeat (3) begin
      @(negedge clk);
      check("stall_dout", 64'(dout), pkt(3, 1, 2, word(0, 2)));
      check("stall_ack", 64'(ack), 64'(0));
    end
    @(posedge clk);
    #1;
    bft_ready = 1'b1;
    @(negedge clk);
    check("ready_ack", 64'(ack), 64'(4'b0001));
    @(posedge clk);
    #1;
    vld = '0;
    cycles(2);

    // Resend blanks the output and the same packet returns.
    exp_q.push_back(pkt(7, 5, 2, word(2, 2)));
    bft_ready = 1'b0;
    vld = 4'b0100;
    cycles(1);
    resend = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("resend_dout", 64'(dout), 64'(0));
      check("resend_ack", 64'(ack), 64'(0));
      @(posedge clk);
      #1;
    end
    resend = 1'b0;
    vld = '0;
    @(negedge clk);
    check("after_resend_dout", 64'(dout), pkt(7, 5, 2, word(2, 2)));
    @(posedge clk);
    #1;
    bft_ready = 1'b1;
    cycles(2);

    // Held packet keeps its destination across a table rewrite.
    exp_q.push_back(pkt(3, 1, 4, word(0, 4)));
    exp_q.push_back(pkt(4, 6, 5, word(0, 5)));
    bft_ready = 1'b0;
    vld = 4'b0001;
    cycles(1);
    vld = '0;
    do_cfg(0, 1'b1, 4, 6);
    vld = 4'b0001;
    bft_ready = 1'b1;
    @(posedge clk);
    #1;
    vld = '0;
    cycles(2);

    // Credits and address wrap on port 1.
    do_cfg(1, 1'b1, 9, 2);
    do_cfg(5, 1'b1, 31, 15);
    credit_port = 4'd1;
    credit_upd  = 1'b1;
    cycles(1);
    credit_upd  = 1'b0;
    for (int k = 0; k < 320; k++) exp_q.push_back(pkt(9, 2, k, word(1, k)));
    base = ack_cnt[1];
    vld = 4'b0010;
    cycles(132);
    @(negedge clk);
    check("credit_empty_ack", 64'(ack), 64'(0));
    check("credit_128_acks", 64'(ack_cnt[1] - base), 64'(128));
    @(posedge clk);
    #1;
    credit_port = 4'd5;
    credit_upd  = 1'b1;
    cycles(1);
    credit_upd  = 1'b0;
    cycles(3);
    @(negedge clk);
    check("bad_credit_port_ack", 64'(ack), 64'(0));
    check("bad_credit_port_cnt", 64'(ack_cnt[1] - base), 64'(128));
    @(posedge clk);
    #1;
    credit_port = 4'd1;
    credit_upd  = 1'b1;
    cycles(1);
    credit_upd  = 1'b0;
    cycles(70);
    @(negedge clk);
    check("refill_ack", 64'(ack), 64'(0));
    check("refill_64_acks", 64'(ack_cnt[1] - base), 64'(192));
    @(posedge clk);
    #1;
    credit_upd = 1'b1;
    cycles(2);
    credit_upd = 1'b0;
    cycles(135);
    @(negedge clk);
    check("net_credit_ack", 64'(ack), 64'(0));
    check("net_credit_acks", 64'(ack_cnt[1] - base), 64'(320));
    @(posedge clk);
    #1;
    vld = '0;
    cycles(3);

    // Reset with a packet in flight.
    bft_ready = 1'b0;
    vld = 4'b0100;
    cycles(1);
    #1;
    reset = 1'b0;
    #1;
    check("rst_dout", 64'(dout), 64'(0));
    check("rst_ack", 64'(ack), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_en_cleared_ack", 64'(ack), 64'(0));
    check("rst_en_cleared_dout", 64'(dout), 64'(0));

    // First grant after reset goes to port 0.
    @(posedge clk);
    #1;
    vld = '0;
    bft_ready = 1'b1;
    do_cfg(0, 1'b1, 1, 1);
    do_cfg(3, 1'b1, 6, 7);
    exp_q.push_back(pkt(1, 1, 0, word(0, 6)));
    exp_q.push_back(pkt(6, 7, 0, word(3, 0)));
    vld = 4'b1001;
    cycles(2);
    vld = '0;
    cycles(2);

    // Credit restored to full on port 2 after reset.
    do_cfg(2, 1'b1, 2, 3);
    for (int k = 4; k < 132; k++) exp_q.push_back(pkt(2, 3, k - 4, word(2, k)));
    base = ack_cnt[2];
    vld = 4'b0100;
    cycles(132);
    @(negedge clk);
    check("post_rst_ack", 64'(ack), 64'(0));
    check("post_rst_credit", 64'(ack_cnt[2] - base), 64'(128));
    @(posedge clk);
    #1;
    vld = '0;
    cycles(3);

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
